// File: rtl/flag_event_scheduler.sv
// Arbitrates one-cycle event requests onto a single spaced flag-pulse channel with a held payload.
// Build option: define FLAG_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module flag_event_scheduler #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int GAP    = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         req_overflow,
    output logic                     flag_out,
    output logic [DATA_W-1:0]        data_out,
    output logic [$clog2(N_REQ)-1:0] src_out,
    output logic                     busy
);
    localparam int SRC_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(GAP);
    localparam logic [CNT_W-1:0] SPACE_LOAD = CNT_W'(GAP - 2);

    typedef enum logic [1:0] {IDLE, ISSUE, SPACE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  spaceCnt;
    logic [N_REQ-1:0]  pend;
    logic [N_REQ-1:0]  pendNxt;
    logic [N_REQ-1:0]  capture;
    logic [N_REQ-1:0]  drop;
    logic [N_REQ-1:0]  grantOh;
    logic [DATA_W-1:0] pdata [N_REQ];
    logic              grantEn;
    logic [SRC_W-1:0]  grantIdx;

`ifdef FLAG_SCHED_FIXED_PRIO_EN
    always_comb begin
        grantIdx = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (pend[i]) grantIdx = SRC_W'(i);
    end
`else
    logic [SRC_W-1:0] lastGrant;

    // Walk downward so the candidate closest after lastGrant overrides the rest.
    always_comb begin
        int               j;
        logic [SRC_W-1:0] idx;
        j        = 0;
        idx      = '0;
        grantIdx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            j = int'(lastGrant) + k;
            if (j >= N_REQ) j = j - N_REQ;
            idx = SRC_W'(j);
            if (pend[idx]) grantIdx = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            lastGrant <= SRC_W'(N_REQ - 1);
        else if (grantEn)
            lastGrant <= grantIdx;
    end
`endif

    assign grantEn = (state == IDLE) && (|pend);

    always_comb begin
        grantOh = '0;
        if (grantEn) grantOh[grantIdx] = 1'b1;
    end

    // A request on the requester being granted this cycle refills its slot instead of overflowing.
    assign capture = req_valid & (~pend | grantOh);
    assign drop    = req_valid & pend & ~grantOh;
    assign pendNxt = (pend & ~grantOh) | capture;

    always_ff @(posedge clk) begin
        if (rst)
            pend <= '0;
        else
            pend <= pendNxt;
        for (int i = 0; i < N_REQ; i++)
            if (capture[i]) pdata[i] <= req_data[i*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            spaceCnt     <= '0;
            flag_out     <= 1'b0;
            data_out     <= '0;
            src_out      <= '0;
            busy         <= 1'b0;
            req_overflow <= '0;
        end else begin
            flag_out     <= 1'b0;
            req_overflow <= drop;
            case (state)
                IDLE: begin
                    if (grantEn) begin
                        state    <= ISSUE;
                        flag_out <= 1'b1;
                        data_out <= pdata[grantIdx];
                        src_out  <= grantIdx;
                        busy     <= 1'b1;
                    end else begin
                        busy <= |pendNxt;
                    end
                end
                ISSUE: begin
                    state    <= SPACE;
                    spaceCnt <= SPACE_LOAD;
                    busy     <= 1'b1;
                end
                SPACE: begin
                    // Leaving on the last count keeps rising edges exactly GAP cycles apart.
                    if (spaceCnt <= CNT_W'(1)) begin
                        state <= IDLE;
                        busy  <= |pendNxt;
                    end else begin
                        busy <= 1'b1;
                    end
                    if (spaceCnt != '0) spaceCnt <= spaceCnt - CNT_W'(1);
                end
                default: begin
                    state <= IDLE;
                    busy  <= |pendNxt;
                end
            endcase
        end
    end

endmodule
